// File: rtl/fifo_feed_sched.sv
// fifo_feed_sched: feeds one tile from ROWS row FIFOs into a systolic array
// with diagonal skew (row r starts r cycles after row 0).
//
// Ports
//   CLK, RST       clock, asynchronous active-high reset
//   start          feed request, sampled only in IDLE
//   tile_len       words per row, sampled with an accepted start
//   fifo_ocp       per-row FIFO occupancy (packed, ROWS x LW)
//   fifo_empty     per-row FIFO empty flags
//   stall          array back-pressure; freezes feeding while high
//   fifo_pop       per-row pop strobe (combinational from registered state)
//   busy           high whenever not IDLE
//   done           one-cycle pulse in the DONE state
//   err_cfg        one-cycle pulse, the cycle after a rejected start
//   err_underflow  sticky; set when a row window hits an empty FIFO

// Per-row window and pop gating.
module fifo_feed_row #(
    parameter int ROW = 0,
    parameter int LW  = 5,
    parameter int TW  = 6
) (
    input  logic          feed_en,   // FEED and not stalled
    input  logic [TW-1:0] t,
    input  logic [LW-1:0] len,
    input  logic          empty,
    output logic          pop,
    output logic          uflow
);
    logic [TW-1:0] row_c;
    logic [TW-1:0] end_x;
    logic          window;

    // Window is row <= t <= row+len-1, written as t < row+len (len >= 1).
    assign row_c  = TW'(ROW);
    assign end_x  = row_c + TW'(len);
    assign window = (t >= row_c) && (t < end_x);
    assign pop    = feed_en & window & ~empty;
    assign uflow  = feed_en & window & empty;
endmodule

module fifo_feed_sched #(
    parameter int ROWS = 4,
    parameter int SIZE = 16
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  start,
    input  logic [$clog2(SIZE):0]                 tile_len,
    input  logic [ROWS-1:0][$clog2(SIZE):0]       fifo_ocp,
    input  logic [ROWS-1:0]                       fifo_empty,
    input  logic                                  stall,
    output logic [ROWS-1:0]                       fifo_pop,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err_cfg,
    output logic                                  err_underflow
);
    localparam int LW = $clog2(SIZE) + 1;
    localparam int TW = $clog2(SIZE + ROWS) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FEED = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic [LW-1:0]   len_q;
    logic [TW-1:0]   t_q;
    logic            cfg_q;
    logic            uf_q;

    logic            len_ok;
    logic            ocp_ok;
    logic            feed_en;
    logic            last;
    logic [ROWS-1:0] uflow;

    assign len_ok  = (tile_len != '0) && (tile_len <= LW'(SIZE));
    assign feed_en = (state == S_FEED) && !stall;
    // Final skew cycle: row ROWS-1 pops its last word at t = len+ROWS-2.
    assign last    = (t_q == TW'(len_q) + TW'(ROWS - 2));

    always_comb begin
        ocp_ok = 1'b1;
        for (int r = 0; r < ROWS; r++)
            if (fifo_ocp[r] < len_q) ocp_ok = 1'b0;
    end

    genvar g;
    generate
        for (g = 0; g < ROWS; g++) begin : g_row
            fifo_feed_row #(.ROW(g), .LW(LW), .TW(TW)) u_row (
                .feed_en (feed_en),
                .t       (t_q),
                .len     (len_q),
                .empty   (fifo_empty[g]),
                .pop     (fifo_pop[g]),
                .uflow   (uflow[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            len_q <= '0;
            t_q   <= '0;
            cfg_q <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            cfg_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q <= tile_len;
                            uf_q  <= 1'b0;
                            t_q   <= '0;
                            state <= S_WAIT;
                        end else begin
                            cfg_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    t_q <= '0;
                    if (ocp_ok) state <= S_FEED;
                end
                S_FEED: begin
                    if (|uflow) uf_q <= 1'b1;
                    if (!stall) begin
                        t_q <= t_q + 1'b1;
                        if (last) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;   // S_DONE
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign err_cfg       = cfg_q;
    assign err_underflow = uf_q;
endmodule

// File: tb/tb_fifo_feed_sched.sv
module tb_fifo_feed_sched;
    localparam int ROWS = 4;
    localparam int SIZE = 16;
    localparam int LW   = 5;

    logic                         CLK;
    logic                         RST;
    logic                         start;
    logic [LW-1:0]                tile_len;
    logic [ROWS-1:0][LW-1:0]      fifo_ocp;
    logic [ROWS-1:0]              fifo_empty;
    logic                         stall;
    logic [ROWS-1:0]              fifo_pop;
    logic                         busy;
    logic                         done;
    logic                         err_cfg;
    logic                         err_underflow;

    fifo_feed_sched #(.ROWS(ROWS), .SIZE(SIZE)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .tile_len      (tile_len),
        .fifo_ocp      (fifo_ocp),
        .fifo_empty    (fifo_empty),
        .stall         (stall),
        .fifo_pop      (fifo_pop),
        .busy          (busy),
        .done          (done),
        .err_cfg       (err_cfg),
        .err_underflow (err_underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic            start;
        logic [LW-1:0]   len;
        logic [LW-1:0]   ocp2;     // row 2 occupancy; other rows hold 16
        logic            stall;
        logic [ROWS-1:0] empty;
        logic [ROWS-1:0] pop;
        logic            busy;
        logic            done;
        logic            cfg;
        logic            uf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic st, int ln, int o2, logic sl, logic [3:0] em,
                                logic [3:0] p, logic b, logic d, logic c, logic u);
        vec_t x;
        x.start = st; x.len = LW'(ln); x.ocp2 = LW'(o2); x.stall = sl; x.empty = em;
        x.pop = p; x.busy = b; x.done = d; x.cfg = c; x.uf = u;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(vec_t x);
        start      = x.start;
        tile_len   = x.len;
        stall      = x.stall;
        fifo_empty = x.empty;
        for (int r = 0; r < ROWS; r++)
            fifo_ocp[r] = (r == 2) ? x.ocp2 : LW'(16);
    endtask

    // Scenario tables: one entry per cycle, c0 is the cycle start is driven.
    task automatic tbl_basic(logic start_in_done, logic uf_at_c0);
        vecs.push_back(mk(1, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, uf_at_c0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1110, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1000, 1, 0, 0, 0));
        vecs.push_back(mk(start_in_done, 3, 16, 0, 4'b0000, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t x, e;
        RST = 1'b0; start = 1'b0; tile_len = '0; stall = 1'b0;
        fifo_empty = '0; fifo_ocp = '0;
        #1 RST = 1'b1;
        #2;
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg", 32'(err_cfg), 0);
        chk("rst_uf", 32'(err_underflow), 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Nominal tile; a start during DONE must be ignored.
        tbl_basic(1'b1, 1'b0);
        // Stall for 2 cycles at t=2; a bad start mid-FEED raises no error.
        vecs.push_back(mk(1, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 16, 0, 4'b0000, 4'b0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 1, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1110, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Row 1 empty across its whole window -> underflow, sticky past done.
        vecs.push_back(mk(1, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0010, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0010, 4'b0101, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0010, 4'b1100, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1100, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 1));
        // Next valid start clears the sticky underflow.
        tbl_basic(1'b0, 1'b1);
        // Rejected starts: tile_len 0 and 17.
        vecs.push_back(mk(1, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        vecs.push_back(mk(1, 17, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Row 2 short on data: hold in WAIT, then release at c5.
        vecs.push_back(mk(1, 3, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(0, 3, 1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b1110, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b1100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b1000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3, 3, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        // Reset lead-in: start a tile and run to FEED t=3 (c5).
        vecs.push_back(mk(1, 3, 16, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0011, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b0111, 1, 0, 0, 0));
        vecs.push_back(mk(0, 3, 16, 0, 4'b0000, 4'b1110, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLK);
            #1;
            x = vecs[i];
            drive(x);
            sb.push_back(x);
            @(negedge CLK);
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL sb_empty[%0d]: got none expected entry", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("pop[%0d]", i),  32'(fifo_pop),      32'(e.pop));
                chk($sformatf("busy[%0d]", i), 32'(busy),          32'(e.busy));
                chk($sformatf("done[%0d]", i), 32'(done),          32'(e.done));
                chk($sformatf("cfg[%0d]", i),  32'(err_cfg),       32'(e.cfg));
                chk($sformatf("uf[%0d]", i),   32'(err_underflow), 32'(e.uf));
            end
        end

        // Asynchronous reset mid-FEED: outputs drop before any clock edge.
        RST = 1'b1;
        #1;
        chk("midrst_pop", 32'(fifo_pop), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk($sformatf("postrst_pop[%0d]", i), 32'(fifo_pop), 0);
            chk($sformatf("postrst_busy[%0d]", i), 32'(busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_feed_sched.md
FIFO_FEED_SCHED -- requirements
Module: fifo_feed_sched

Interface
REQ-001 Parameter ROWS, default 4: number of row FIFOs feeding the systolic array, one per array row.
REQ-002 Parameter SIZE, default 16: depth of each row FIFO; occupancy width is $clog2(SIZE)+1.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to feed one tile; sampled only in IDLE.
REQ-006 tile_len  in  $clog2(SIZE)+1  words per row for this tile; sampled with start.
REQ-007 fifo_ocp  in  ROWS x ($clog2(SIZE)+1)  per-row FIFO occupancy.
REQ-008 fifo_empty  in  ROWS  per-row FIFO is_empty.
REQ-009 stall  in  1  array back-pressure; freezes feeding while high.
REQ-010 fifo_pop  out  ROWS  per-row pop strobe; FIFO head is valid to the array in the same cycle.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at tile completion.
REQ-013 err_cfg  out  1  one-cycle pulse on a rejected start.
REQ-014 err_underflow  out  1  sticky; cleared by the next accepted start or by RST.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, FEED and DONE, held in registers.
REQ-016 IDLE: start with 1 <= tile_len <= SIZE SHALL latch tile_len, clear err_underflow and go to WAIT on the next edge.
REQ-017 IDLE: start with tile_len == 0 or tile_len > SIZE SHALL pulse err_cfg for one cycle and remain in IDLE.
REQ-018 start outside IDLE SHALL be ignored, with no error and no relatch.
REQ-019 WAIT: when every fifo_ocp[r] >= latched tile_len, the FSM SHALL go to FEED on the next edge; otherwise it stays in WAIT with all pops low.
REQ-020 FEED: skew counter t starts at 0; width $clog2(SIZE+ROWS)+1.
REQ-021 FEED: row r window SHALL be active when r <= t <= r+tile_len-1, giving diagonal skew with row r delayed r cycles from row 0.
REQ-022 fifo_pop[r] SHALL equal (state==FEED) & window[r] & !stall & !fifo_empty[r]; it is combinational from registered state, t and inputs.
REQ-023 stall high SHALL force all fifo_pop low and hold t; t increments only on non-stalled FEED cycles.
REQ-024 Window active, stall low and fifo_empty[r] high SHALL set err_underflow; that row's pop is suppressed and t still advances.
REQ-025 FEED exit: on the non-stalled cycle with t == tile_len+ROWS-2, the FSM SHALL go to DONE on the next edge.
REQ-026 An unstalled tile SHALL occupy exactly tile_len+ROWS-1 FEED cycles, with exactly tile_len pops per row absent underflow.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; start in the DONE cycle is ignored.
REQ-028 Latency from accepted start to first pop SHALL be 2 cycles when occupancy is already sufficient.

Reset
REQ-029 RST high SHALL immediately force state=IDLE, t=0, latched tile_len=0, fifo_pop=0, busy=0, done=0, err_cfg=0 and err_underflow=0, independent of CLK.
REQ-030 RST asserted mid-FEED SHALL drop all pops in the same cycle; after RST deasserts, no feeding resumes until a new start.

Verification
REQ-031 ROWS=4, tile_len=3, all ocp=16, stall=0, start at cycle 0 -> WAIT at c1; FEED c2-c7; row0 pops c2-c4, row1 c3-c5, row2 c4-c6, row3 c5-c7; done at c8; busy c1-c8.
REQ-032 tile_len=3, row2 ocp=1 -> held in WAIT with pops 0; raise row2 ocp to 3 -> FEED begins the following cycle.
REQ-033 stall=1 for 2 cycles at FEED t=2 -> all pops 0 and t held at 2 during the stall; each row still gets exactly 3 pops; done is delayed by 2 cycles (c10).
REQ-034 start with tile_len=0, then tile_len=17 -> err_cfg pulses each time; busy stays 0; no pops.
REQ-035 fifo_empty[1]=1 during row1 window -> fifo_pop[1]=0 and err_underflow=1, held through done; next valid start clears it.
REQ-036 RST pulse at FEED t=3 -> fifo_pop=0 and busy=0 immediately; after RST release the block stays idle with no pops until start.
